// File: rtl/pe_seq.sv
// pe_seq: issue/collect sequencer for one RAVEN PE. Aligns operands to the PE latency,
// saturates each result to Q(INT_BW).(FRA_BW) and returns it in order through a credited FIFO.
`default_nettype none

module pe_seq #(
  parameter int INT_BW     = 5,
  parameter int FRA_BW     = 10,
  parameter int MUL_BW     = 16,
  parameter int ACC_BW     = 32,
  parameter int LAT_GEMM   = 2,
  parameter int LAT_UNO    = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_mode,
  input  logic [MUL_BW-1:0] in_x,
  input  logic [MUL_BW-1:0] in_y,
  input  logic [ACC_BW-1:0] in_acc,
  output logic [1:0]        pe_gemm_uno,
  output logic [MUL_BW-1:0] pe_x,
  output logic [MUL_BW-1:0] pe_wc,
  output logic [ACC_BW-1:0] pe_o,
  output logic [ACC_BW-1:0] pe_mac,
  input  logic [ACC_BW-1:0] pe_res,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [MUL_BW-1:0] out_data,
  output logic              out_sat,
  output logic [1:0]        out_mode
);

  // Both latencies must be >= 2 so the side operand leaves through a register stage.
  localparam int LMAX = (LAT_GEMM > LAT_UNO) ? LAT_GEMM : LAT_UNO;
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int CW   = $clog2(FIFO_DEPTH + 1);
  localparam int TOP  = INT_BW + 2 * FRA_BW;
  localparam logic [LMAX-1:0] KEEP_GEMM = ~(LMAX'(1) << LAT_GEMM);
  localparam logic [LMAX-1:0] KEEP_UNO  = ~(LMAX'(1) << LAT_UNO);
  localparam logic [CW:0]     DEPTH_C   = (CW + 1)'(FIFO_DEPTH);

  logic [1:0]        cur_mode;
  logic [LMAX:0]     tag;
  logic [ACC_BW-1:0] acc_dly [LMAX-1];
  logic [CW-1:0]     in_flight;
  logic [CW-1:0]     count;
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [MUL_BW-1:0] mem_data [FIFO_DEPTH];
  logic              mem_sat  [FIFO_DEPTH];
  logic [1:0]        mem_mode [FIFO_DEPTH];

  logic                  fire;
  logic                  pop;
  logic                  is_gemm;
  logic                  side_due;
  logic                  capture;
  logic [ACC_BW-1:0]     side_val;
  logic [LMAX-1:0]       keep;
  logic [CW:0]           used;
  logic [ACC_BW-TOP-1:0] hi;
  logic                  ovf;
  logic [MUL_BW-1:0]     sat_data;
  logic                  unused_frac;

  assign is_gemm  = (cur_mode == 2'b00);
  assign used     = {1'b0, in_flight} + {1'b0, count};
  // Credit uses registered counts only, so the FIFO can never overflow.
  assign in_ready = (used < DEPTH_C) && ((in_mode == cur_mode) || (in_flight == '0));
  assign fire     = in_valid && in_ready;
  assign out_valid = (count != '0);
  assign pop      = out_valid && out_ready;

  // The mode is frozen while anything is in flight, so one tap set serves all live tags.
  assign side_due = is_gemm ? tag[LAT_GEMM-2] : tag[LAT_UNO-2];
  assign side_val = is_gemm ? acc_dly[LAT_GEMM-2] : acc_dly[LAT_UNO-2];
  assign capture  = is_gemm ? tag[LAT_GEMM] : tag[LAT_UNO];
  assign keep     = is_gemm ? KEEP_GEMM : KEEP_UNO;

  // In range iff every bit from the Q5.20 sign position upward agrees.
  assign hi       = pe_res[ACC_BW-1:TOP];
  assign ovf      = !((&hi) || !(|hi));
  assign sat_data = ovf ? (pe_res[ACC_BW-1] ? {1'b1, {(MUL_BW-1){1'b0}}}
                                            : {1'b0, {(MUL_BW-1){1'b1}}})
                        : pe_res[TOP:FRA_BW];
  assign unused_frac = ^pe_res[FRA_BW-1:0];

  assign pe_gemm_uno = cur_mode;
  assign out_data    = out_valid ? mem_data[rd_ptr] : '0;
  assign out_sat     = out_valid ? mem_sat[rd_ptr]  : 1'b0;
  assign out_mode    = out_valid ? mem_mode[rd_ptr] : 2'b00;

  always_ff @(posedge clk) begin
    if (rst_n) begin
      cur_mode  <= 2'b00;
      tag       <= '0;
      in_flight <= '0;
      count     <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      pe_x      <= '0;
      pe_wc     <= '0;
      pe_o      <= '0;
      pe_mac    <= '0;
      for (int i = 0; i < LMAX - 1; i++) acc_dly[i] <= '0;
    end else begin
      if (fire) cur_mode <= in_mode;
      // A tag is dropped once it reaches its capture tap.
      tag       <= {tag[LMAX-1:0] & keep, fire};
      in_flight <= in_flight + CW'(fire) - CW'(capture);
      count     <= count + CW'(capture) - CW'(pop);
      if (capture) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      pe_x       <= fire ? in_x : '0;
      pe_wc      <= fire ? in_y : '0;
      acc_dly[0] <= fire ? in_acc : '0;
      for (int i = 1; i < LMAX - 1; i++) acc_dly[i] <= acc_dly[i-1];
      pe_o   <= (side_due && is_gemm)  ? side_val : '0;
      pe_mac <= (side_due && !is_gemm) ? side_val : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (capture) begin
      mem_data[wr_ptr] <= sat_data;
      mem_sat[wr_ptr]  <= ovf;
      mem_mode[wr_ptr] <= cur_mode;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_pe_seq.sv
// tb_pe_seq: directed bench for pe_seq with a two-cycle PE model and an in-order scoreboard.
`default_nettype none

module tb_pe_seq;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_mode;
  logic [15:0] in_x;
  logic [15:0] in_y;
  logic [31:0] in_acc;
  logic [1:0]  pe_gemm_uno;
  logic [15:0] pe_x;
  logic [15:0] pe_wc;
  logic [31:0] pe_o;
  logic [31:0] pe_mac;
  logic [31:0] pe_res;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        out_sat;
  logic [1:0]  out_mode;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;
  logic [18:0] exp_q [$];
  logic [18:0] exp_e;
  logic        stream_done;
  logic signed [31:0] p1;

  pe_seq dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
    .in_x(in_x), .in_y(in_y), .in_acc(in_acc),
    .pe_gemm_uno(pe_gemm_uno), .pe_x(pe_x), .pe_wc(pe_wc),
    .pe_o(pe_o), .pe_mac(pe_mac), .pe_res(pe_res),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_sat(out_sat), .out_mode(out_mode)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // PE model, latency 2: product from the x/wc cycle, side operand added one cycle later.
  always @(posedge clk) begin
    p1     <= $signed(pe_x) * $signed(pe_wc);
    pe_res <= p1 + ((pe_gemm_uno == 2'b00) ? pe_o : pe_mac);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  function automatic logic [18:0] ref_res(input logic [1:0] m, input logic [15:0] x,
                                          input logic [15:0] y, input logic [31:0] a);
    logic signed [31:0] r;
    r = $signed(a) + $signed(x) * $signed(y);
    if (r > 32'sd33554431)       return {m, 1'b1, 16'h7FFF};
    else if (r < -32'sd33554432) return {m, 1'b1, 16'h8000};
    else                         return {m, 1'b0, r[25:10]};
  endfunction

  // Results leave at the posedge following a negedge where valid&ready are both seen.
  always @(negedge clk) begin
    if (rst_n) exp_q.delete();
    else if (out_valid && out_ready) begin
      if (exp_q.size() == 0) chk("spurious_out", 32'(out_valid), 32'd0);
      else begin
        exp_e = exp_q.pop_front();
        chk("out_data", 32'(out_data), 32'(exp_e[15:0]));
        chk("out_sat",  32'(out_sat),  32'(exp_e[16]));
        chk("out_mode", 32'(out_mode), 32'(exp_e[18:17]));
      end
    end
  end

  // Called just after a posedge; returns just after the accepting posedge.
  task automatic issue(input logic [1:0] m, input logic [15:0] x, input logic [15:0] y,
                       input logic [31:0] a, input logic [15:0] ed, input logic es);
    in_valid = 1'b1; in_mode = m; in_x = x; in_y = y; in_acc = a;
    for (int b = 0; b < 50; b++) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back({m, es, ed});
        @(posedge clk); #1;
        in_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("issue_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain();
    for (int b = 0; b < 100 && exp_q.size() != 0; b++) @(posedge clk);
    #1;
    chk("drain_left", 32'(exp_q.size()), 32'd0);
    @(negedge clk);
    chk("idle_valid", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int blocked;
    int c0;
    logic [15:0] rx, ry;
    logic [31:0] ra;
    rst_n = 1'b1; in_valid = 1'b0; in_mode = 2'b00; in_x = '0; in_y = '0; in_acc = '0;
    out_ready = 1'b1; stream_done = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_in_ready",  32'(in_ready),    32'd1);
    chk("rst_out_valid", 32'(out_valid),   32'd0);
    chk("rst_out_data",  32'(out_data),    32'd0);
    chk("rst_out_sat",   32'(out_sat),     32'd0);
    chk("rst_out_mode",  32'(out_mode),    32'd0);
    chk("rst_pe_mode",   32'(pe_gemm_uno), 32'd0);
    chk("rst_pe_x",      32'(pe_x),        32'd0);
    chk("rst_pe_o",      pe_o,             32'd0);
    @(posedge clk); #1;

    // Basic gemm timing: 1.0 * 2.0 = 2.0
    issue(2'b00, 16'h0400, 16'h0800, 32'd0, 16'h0800, 1'b0);
    @(negedge clk);
    chk("t1_pe_x",  32'(pe_x),  32'h0400);
    chk("t1_pe_wc", 32'(pe_wc), 32'h0800);
    @(posedge clk); #1; @(negedge clk);
    chk("t2_pe_x", 32'(pe_x), 32'd0);
    chk("t2_pe_o", pe_o,      32'd0);
    @(posedge clk); #1; @(negedge clk);
    chk("t3_out_valid", 32'(out_valid), 32'd0);
    @(posedge clk); #1; @(negedge clk);
    chk("t4_out_valid", 32'(out_valid), 32'd1);
    chk("t4_out_data",  32'(out_data),  32'h0800);
    @(posedge clk); #1;
    drain();

    // Saturation boundaries; first op also checks side-operand alignment
    issue(2'b00, 16'h0000, 16'h0000, 32'h7FFF_FFFF, 16'h7FFF, 1'b1);
    @(negedge clk);
    chk("side_t1_pe_o", pe_o, 32'd0);
    @(posedge clk); #1; @(negedge clk);
    chk("side_t2_pe_o",   pe_o,   32'h7FFF_FFFF);
    chk("side_t2_pe_mac", pe_mac, 32'd0);
    @(posedge clk); #1; @(negedge clk);
    chk("side_t3_pe_o", pe_o, 32'd0);
    @(posedge clk); #1;
    issue(2'b00, 16'h0000, 16'h0000, 32'h8000_0000, 16'h8000, 1'b1);
    issue(2'b00, 16'h0000, 16'h0000, 32'h0200_0000, 16'h7FFF, 1'b1);
    issue(2'b00, 16'h0000, 16'h0000, 32'h01FF_FC00, 16'h7FFF, 1'b0);
    drain();

    // Credit limit with a stalled consumer
    out_ready = 1'b0;
    for (int k = 1; k <= 4; k++) issue(2'b00, 16'h0, 16'h0, 32'(k) << 10, 16'(k), 1'b0);
    in_valid = 1'b1; in_acc = 32'd5 << 10;
    repeat (5) begin
      @(negedge clk);
      chk("credit_block", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("full_head_valid", 32'(out_valid), 32'd1);
    chk("full_head_data",  32'(out_data),  32'd1);
    @(posedge clk); #1;
    out_ready = 1'b1;
    issue(2'b00, 16'h0, 16'h0, 32'd5 << 10, 16'd5, 1'b0);
    issue(2'b00, 16'h0, 16'h0, 32'd6 << 10, 16'd6, 1'b0);
    drain();

    // Mode lock: div waits for the gemm result to be captured
    issue(2'b00, 16'h0400, 16'h0400, 32'd0, 16'h0400, 1'b0);
    in_valid = 1'b1; in_mode = 2'b01; in_x = '0; in_y = '0; in_acc = 32'h0000_0C00;
    blocked = 0;
    for (int b = 0; b < 20; b++) begin
      @(negedge clk);
      if (in_ready) break;
      chk("lock_pe_mode", 32'(pe_gemm_uno), 32'd0);
      blocked++;
      @(posedge clk); #1;
    end
    exp_q.push_back({2'b01, 1'b0, 16'h0003});
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("lock_cycles", 32'(blocked), 32'd3);
    @(negedge clk);
    chk("switch_pe_mode", 32'(pe_gemm_uno), 32'd1);
    @(posedge clk); #1;
    drain();

    // Reset with two ops in flight and one buffered
    out_ready = 1'b0;
    issue(2'b10, 16'h0, 16'h0, 32'h400, 16'h1, 1'b0);
    issue(2'b10, 16'h0, 16'h0, 32'h400, 16'h1, 1'b0);
    issue(2'b10, 16'h0, 16'h0, 32'h400, 16'h1, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    chk("mrst_out_valid", 32'(out_valid),   32'd0);
    chk("mrst_in_ready",  32'(in_ready),    32'd1);
    chk("mrst_pe_mode",   32'(pe_gemm_uno), 32'd0);
    chk("mrst_pe_x",      32'(pe_x),        32'd0);
    chk("mrst_pe_mac",    pe_mac,           32'd0);
    chk("mrst_out_data",  32'(out_data),    32'd0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    repeat (6) begin
      @(negedge clk);
      chk("no_stale", 32'(out_valid), 32'd0);
      @(posedge clk); #1;
    end
    issue(2'b00, 16'h0C00, 16'hFC00, 32'd0, 16'hF400, 1'b0);
    drain();

    // Sustained issue with a ready consumer
    c0 = cyc;
    for (int i = 0; i < 8; i++) issue(2'b00, 16'h0, 16'h0, 32'(i) << 10, 16'(i), 1'b0);
    chk("throughput", 32'((cyc - c0) <= 10), 32'd1);
    drain();

    // 20-op stream against a randomly stalling consumer
    fork
      begin
        for (int i = 0; i < 20; i++) begin
          rx = 16'($urandom);
          ry = 16'($urandom_range(0, 16'h0FFF));
          ra = 32'($urandom_range(0, 32'h03FF_FFFF)) - 32'h0200_0000;
          exp_e = ref_res(2'b00, rx, ry, ra);
          issue(2'b00, rx, ry, ra, exp_e[15:0], exp_e[16]);
        end
        stream_done = 1'b1;
      end
      begin
        while (!stream_done) begin
          @(posedge clk); #1;
          out_ready = 1'(($urandom_range(0, 1)));
        end
      end
    join
    out_ready = 1'b1;
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pe_seq.md
Name: pe_seq

Overview:
- Issue/collect sequencer that sits on the other end of a single RAVEN PE's operand and result ports.
- Accepts operations (mode, x, y, side accumulator) over a valid/ready stream and drives the PE inputs with correct timing alignment.
- Captures the PE's 32-bit result after the mode-dependent latency and saturates it to Q(INT_BW).(FRA_BW) fixed point.
- Returns results in order through a credit-protected output FIFO with valid/ready backpressure.

Parameters:
INT_BW, 5, integer bits of fixed-point operand
FRA_BW, 10, fraction bits of fixed-point operand
MUL_BW, 16, operand width (1+INT_BW+FRA_BW)
ACC_BW, 32, accumulator/result width
LAT_GEMM, 2, cycles from pe_x/pe_wc presentation to pe_res valid in gemm mode
LAT_UNO, 2, same latency for modes 01/10/11 (>=2)
FIFO_DEPTH, 4, output FIFO entries; also max in-flight + buffered ops (power of 2, >=2)

Ports:
clk  in  1  clock
rst_n  in  1  synchronous reset, active-high (1 = reset), sampled on posedge clk
in_valid  in  1  operation valid
in_ready  out  1  operation accepted when in_valid&in_ready at posedge
in_mode  in  2  00 gemm, 01 div, 10 exp, 11 log
in_x  in  MUL_BW  x operand
in_y  in  MUL_BW  weight (gemm) / y operand (unary)
in_acc  in  ACC_BW  partial sum (gemm) / mac input (unary)
pe_gemm_uno  out  2  PE mode
pe_x  out  MUL_BW  PE x_i
pe_wc  out  MUL_BW  PE wc_i
pe_o  out  ACC_BW  PE o_i (gemm side operand)
pe_mac  out  ACC_BW  PE mac_i (unary side operand)
pe_res  in  ACC_BW  PE mac_o/o_o
out_valid  out  1  result valid
out_ready  in  1  result consumed when out_valid&out_ready
out_data  out  MUL_BW  saturated result
out_sat  out  1  result was clamped
out_mode  out  2  mode of the op that produced the result

Behaviour:
- All pe_* outputs are registers. Reset: all pe_* = 0, pe_gemm_uno = 00, FIFO empty, out_valid = 0, out_data = 0, out_sat = 0, out_mode = 00, in-flight count 0, current mode 00. Reset mid-operation discards all in-flight and buffered results; no output appears for them.
- Issue at edge t (handshake): pe_x = in_x and pe_wc = in_y during cycle t+1; pe_gemm_uno = in_mode.
- Non-issue cycles: pe_x and pe_wc return to 0.
- Side operand (in_acc) is delayed LAT-1 cycles: presented during cycle t+LAT (pe_o for gemm, pe_mac for unary); the unused one is 0. It returns to 0 when no op is due.
- A LAT-deep shift register of valid+mode tags marks the capture cycle. pe_res is sampled at edge t+LAT+1 and written to the FIFO. Back-to-back issue gives one result per cycle.
- Mode lock: pe_gemm_uno changes only when in-flight count = 0. in_ready = 0 if in_mode != current mode and in-flight != 0. The new mode is latched at the accepting edge.
- Credit: in_ready = 0 when in-flight + FIFO occupancy >= FIFO_DEPTH. This uses registered counts only; a same-cycle pop does not grant a credit. FIFO overflow is therefore impossible.
- Saturation (Q5.20 -> Q5.10), applied at FIFO write:
  - res > 2^(INT_BW+2*FRA_BW)-1 -> 0x7FFF, sat = 1.
  - res < -2^(INT_BW+2*FRA_BW) -> 0x8000, sat = 1.
  - Else out_data = res[2*FRA_BW+INT_BW : FRA_BW], sat = 0.
- FIFO: first-word-fall-through. out_valid = !empty. Simultaneous push and pop at full or empty are legal; occupancy is unchanged. Pointers wrap modulo FIFO_DEPTH. Order is strictly preserved.
- in_ready is independent of in_valid. in_* are ignored when not accepted.

Test Plan:
- Reset, then gemm op x=0x0400, y=0x0800, acc=0, PE model LAT_GEMM=2 -> pe_x=0x0400 at t+1, pe_o=0 at t+2, out_data=0x0800, out_sat=0, out_mode=00, out_valid at t+4.
- Gemm x=0, acc=0x7FFF_FFFF -> out_data=0x7FFF, sat=1. Gemm x=0, acc=0x8000_0000 -> out_data=0x8000, sat=1. Gemm x=0, acc=0x0200_0000 -> 0x7FFF, sat=1. Gemm x=0, acc=0x01FF_FC00 -> 0x7FFF, sat=0.
- out_ready=0, 6 back-to-back ops with acc=1..6 (x=0) -> exactly 4 accepted, then in_ready=0. Raise out_ready -> 4 results in order, then the remaining 2 accepted.
- Gemm op then div op on the next cycle -> in_ready=0 until the gemm result is captured. pe_gemm_uno switches 00->01 only after drain. Both results emerge in order.
- rst_n=1 for one cycle while 2 ops are in flight and 1 is buffered -> all outputs return to reset values next cycle. No stale result ever appears. A new op after reset completes normally.
- Continuous stream of 20 gemm ops with random out_ready -> no loss or duplication, results match scoreboard, full throughput when out_ready=1.
